mips_data_mem_ctrl: RTL and testbench
=====================================

Name: mips_data_mem_ctrl

Overview:
- Sits between the mips_cpu_harvard data port and a word-organised synchronous data RAM.
- Performs sub-word loads with sign or zero extension, based on the opcode the CPU presents.
- Performs sub-word stores as a read-modify-write, stalling the CPU through cpu_waitrequest.
- Memory is big-endian: byte offset 0 maps to bits 31:24.

Parameters:
- ADDR_W, 10, RAM word-address width (1024 words).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_address  in  32  byte address from CPU
- cpu_read  in  1  load request
- cpu_write  in  1  store request
- cpu_opcode  in  6  instruction opcode[31:26] of the current access
- cpu_writedata  in  32  store data, right-aligned for SB/SH
- cpu_readdata  out  32  extended load result
- cpu_waitrequest  out  1  high = CPU must hold request and stall
- mem_err  out  1  one-cycle pulse on misaligned or illegal access
- ram_address  out  ADDR_W  word address, equal to cpu_address[ADDR_W+1:2] (upper bits ignored, wraps)
- ram_read  out  1  RAM read strobe; data valid the following cycle
- ram_write  out  1  RAM full-word write strobe
- ram_writedata  out  32  word to write
- ram_readdata  in  32  RAM read data, one cycle after ram_read

Behaviour:
- Opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B. Any other opcode is treated as word access (LW/SW).
- FSM states: IDLE, LOAD, RMW, ERR.
- Request acceptance in IDLE: capture opcode, addr[1:0], cpu_writedata and word address into registers.
- Later states drive ram_address, extraction and merge from the captured values only.
- Load (IDLE, cpu_read=1, aligned):
  - Cycle 0: ram_read=1, cpu_waitrequest=1, go to LOAD.
  - LOAD cycle: cpu_readdata = extracted ram_readdata, cpu_waitrequest=0, return to IDLE. Total latency 2 cycles.
- SW (aligned): single cycle. ram_write=1, ram_writedata=cpu_writedata, cpu_waitrequest=0, stay in IDLE.
- SB/SH (aligned):
  - Cycle 0: ram_read=1, cpu_waitrequest=1, go to RMW.
  - RMW cycle: ram_write=1, ram_writedata = ram_readdata with target lane(s) replaced, cpu_waitrequest=0, go to IDLE.
- Load extraction:
  - LB/LBU select byte (3-addr[1:0]).
  - LH/LHU select half-word addr[1]=0 → 31:16, addr[1]=1 → 15:0.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Misaligned access: LH/LHU/SH with addr[0]=1, or word access with addr[1:0]≠0.
  - No RAM strobe is issued.
  - Cycle 0: cpu_waitrequest=1, go to ERR.
  - ERR cycle: mem_err=1, cpu_readdata=0, cpu_waitrequest=0, return to IDLE.
- cpu_read and cpu_write both high: handled as an illegal access, same path as misaligned.
- IDLE with no request: all strobes 0, cpu_waitrequest=0, cpu_readdata holds its last value.
- cpu_readdata is registered, updated only in LOAD (to the extracted value) and ERR (to 0).
- A request present while in LOAD, RMW or ERR is ignored. The CPU holds its request until it sees cpu_waitrequest=0; it is re-evaluated in IDLE only as a new access.
- Reset asserted (reset=0), including mid-LOAD or mid-RMW:
  - Immediately go to IDLE; cpu_readdata=0, mem_err=0, captured registers 0.
  - ram_read, ram_write and cpu_waitrequest are forced to 0 while reset=0.
  - An interrupted RMW never writes.
- Reset deassert: the first accepted request is processed normally in that cycle.
- Word address wraps modulo 2^ADDR_W.

Decomposition:
- Package mips_mem_pkg:
  - Opcode localparams (OP_LB … OP_SW).
  - State enum typedef mem_state_t {IDLE, LOAD, RMW, ERR}.
  - Function is_misaligned(opcode, addr[1:0]).
- Sub-module mips_mem_lane (combinational) provides two functions:
  - extract(word, offset, opcode) → 32-bit result.
  - merge(word, data, offset, opcode) → 32-bit word.
- Top level holds the FSM, capture registers and output registers.

Test Plan:
- RAM[5]=0x8899AABB; LB at 0x15 → cpu_readdata=0xFFFFFF99 on cycle 2; LBU at 0x15 → 0x00000099; waitrequest high exactly 1 cycle.
- RAM[5]=0x8899AABB; LH at 0x16 → 0xFFFFAABB; LHU at 0x14 → 0x00008899; LW at 0x14 → 0x8899AABB.
- RAM[2]=0x11223344; SB at 0x0B with writedata 0x000000EE → ram_write once with 0x112233EE, 2 cycles; SH at 0x08 with 0x0000CAFE → 0xCAFE3344.
- SW at 0x20 with 0xDEADBEEF → ram_write in the same cycle, waitrequest stays 0, RAM[8]=0xDEADBEEF.
- LW at 0x13 → no ram_read/ram_write, mem_err pulse 1 cycle, cpu_readdata=0; SH at 0x09 → same, RAM unchanged; cpu_read=cpu_write=1 → mem_err.
- Assert reset=0 during the RMW cycle of an SB → ram_write never asserts, RAM unchanged; after release, LW at 0x00 completes normally in 2 cycles.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory controller.
//   - opcode constants for the load/store instructions handled
//   - FSM state encoding
//   - access-size decode and alignment check helpers
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {IDLE, LOAD, RMW, ERR} mem_state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_t;

    // Unknown opcodes fall through to word access.
    function automatic acc_size_t op_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
        case (op_size(op))
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_mem_lane.sv
// Big-endian byte-lane logic (purely combinational).
//   word      : RAM word being read
//   data      : right-aligned store data
//   offset    : byte offset within the word (0 = bits 31:24)
//   opcode    : access opcode, selects size and extension
//   extracted : load result, sign/zero extended
//   merged    : word with the addressed lane(s) replaced by data
module mips_mem_lane
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  logic [5:0]  opcode,
    output logic [31:0] extracted,
    output logic [31:0] merged
);

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                            input logic [5:0] op);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        h = off[1] ? w[15:0] : w[31:16];
        case (op_size(op))
            SZ_BYTE: return {{24{(op == OP_LB) & b[7]}}, b};
            SZ_HALF: return {{16{(op == OP_LH) & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [1:0] off, input logic [5:0] op);
        logic [31:0] r;
        r = w;
        case (op_size(op))
            SZ_BYTE: begin
                case (off)
                    2'd0:    r[31:24] = d[7:0];
                    2'd1:    r[23:16] = d[7:0];
                    2'd2:    r[15:8]  = d[7:0];
                    default: r[7:0]   = d[7:0];
                endcase
            end
            SZ_HALF: begin
                if (off[1]) r[15:0]  = d[15:0];
                else        r[31:16] = d[15:0];
            end
            default: r = d;
        endcase
        return r;
    endfunction

    assign extracted = extract(word, offset, opcode);
    assign merged    = merge(word, data, offset, opcode);

endmodule

// File: rtl/mips_data_mem_ctrl.sv
// Data-port bridge between the MIPS CPU and a word-wide synchronous RAM.
// Handles sub-word loads (with extension), sub-word stores via
// read-modify-write, and flags misaligned/illegal accesses.
//   clk, reset (async, active low)
//   cpu_*  : CPU data port (address, read, write, opcode, writedata,
//            readdata, waitrequest)
//   mem_err: one-cycle pulse on a rejected access
//   ram_*  : RAM port (address, read, write, writedata, readdata)
module mips_data_mem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [5:0]        cpu_opcode,
    input  logic [31:0]       cpu_writedata,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
    output logic              mem_err,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read,
    output logic              ram_write,
    output logic [31:0]       ram_writedata,
    input  logic [31:0]       ram_readdata
);

    mem_state_t        state;
    logic [5:0]        op_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       rdata_q;

    logic [31:0] extracted, merged;
    logic        req, illegal, is_sw;

    // Upper address bits are deliberately dropped: the word address wraps.
    logic unused_addr;
    assign unused_addr = ^cpu_address[31:ADDR_W+2];

    assign req     = cpu_read | cpu_write;
    assign illegal = (cpu_read & cpu_write) | is_misaligned(cpu_opcode, cpu_address[1:0]);
    assign is_sw   = cpu_write & (op_size(cpu_opcode) == SZ_WORD);

    mips_mem_lane u_lane (
        .word      (ram_readdata),
        .data      (wdata_q),
        .offset    (off_q),
        .opcode    (op_q),
        .extracted (extracted),
        .merged    (merged)
    );

    // Strobes must go out in the request cycle itself, so they are decoded
    // from the live request in IDLE and from captured state afterwards.
    always_comb begin
        ram_address     = (state == IDLE) ? cpu_address[ADDR_W+1:2] : waddr_q;
        ram_writedata   = (state == RMW) ? merged : cpu_writedata;
        ram_read        = 1'b0;
        ram_write       = 1'b0;
        cpu_waitrequest = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (illegal) begin
                            cpu_waitrequest = 1'b1;
                        end else if (is_sw) begin
                            ram_write = 1'b1;
                        end else begin
                            ram_read        = 1'b1;
                            cpu_waitrequest = 1'b1;
                        end
                    end
                end
                RMW:     ram_write = 1'b1;
                default: ;
            endcase
        end
    end

    // Load data is presented during the LOAD cycle (CPU samples at its end);
    // rdata_q keeps it visible afterwards.
    always_comb begin
        case (state)
            LOAD:    cpu_readdata = extracted;
            ERR:     cpu_readdata = 32'h0;
            default: cpu_readdata = rdata_q;
        endcase
    end

    assign mem_err = (state == ERR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            op_q    <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            waddr_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_q    <= cpu_opcode;
                        off_q   <= cpu_address[1:0];
                        wdata_q <= cpu_writedata;
                        waddr_q <= cpu_address[ADDR_W+1:2];
                        if (illegal)       state <= ERR;
                        else if (cpu_read) state <= LOAD;
                        else if (is_sw)    state <= IDLE;
                        else               state <= RMW;
                    end
                end
                LOAD: begin
                    rdata_q <= extracted;
                    state   <= IDLE;
                end
                RMW: state <= IDLE;
                ERR: begin
                    rdata_q <= 32'h0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_data_mem_ctrl.sv
// Directed test of mips_data_mem_ctrl against a behavioural synchronous RAM.
module tb_mips_data_mem_ctrl;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [31:0]       cpu_address = '0;
    logic              cpu_read = 1'b0, cpu_write = 1'b0;
    logic [5:0]        cpu_opcode = '0;
    logic [31:0]       cpu_writedata = '0;
    logic [31:0]       cpu_readdata;
    logic              cpu_waitrequest, mem_err;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_read, ram_write;
    logic [31:0]       ram_writedata;
    logic [31:0]       ram_readdata = '0;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    mips_data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_opcode(cpu_opcode), .cpu_writedata(cpu_writedata),
        .cpu_readdata(cpu_readdata), .cpu_waitrequest(cpu_waitrequest),
        .mem_err(mem_err),
        .ram_address(ram_address), .ram_read(ram_read), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
    );

    always @(posedge clk) begin
        if (ram_write) mem[ram_address] <= ram_writedata;
        if (ram_read)  ram_readdata <= mem[ram_address];
    end

    typedef struct {
        string       name;
        logic [31:0] rdata;
        bit          chk_rd;
        int          nerr;
        int          waits;
        int          nrd;
        int          nwr;
        logic [31:0] wdata;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic exp_t mk(input string n, input logic [31:0] rd, input bit c,
                                input int er, input int w, input int nr, input int nw,
                                input logic [31:0] wd);
        exp_t e;
        e.name = n; e.rdata = rd; e.chk_rd = c; e.nerr = er;
        e.waits = w; e.nrd = nr; e.nwr = nw; e.wdata = wd;
        return e;
    endfunction

    // Monitor: accumulates strobes/waits per transaction, checks on completion.
    int wc = 0, nrd = 0, nwr = 0, nerr = 0;
    logic [31:0] lastw = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            wc = 0; nrd = 0; nwr = 0; nerr = 0;
        end else begin
            if (ram_read) nrd++;
            if (ram_write) begin nwr++; lastw = ram_writedata; end
            if (mem_err) nerr++;
            if (cpu_read | cpu_write) begin
                if (cpu_waitrequest) wc++;
                else begin
                    if (q.size() == 0) begin
                        nvec++; nfail++;
                        $display("FAIL unexpected_completion: got 1 expected 0");
                    end else begin
                        e = q.pop_front();
                        if (e.chk_rd) chk({e.name, ".rdata"}, cpu_readdata, e.rdata);
                        chk({e.name, ".waits"}, wc, e.waits);
                        chk({e.name, ".ram_read"}, nrd, e.nrd);
                        chk({e.name, ".ram_write"}, nwr, e.nwr);
                        chk({e.name, ".mem_err"}, nerr, e.nerr);
                        if (e.nwr != 0) chk({e.name, ".wdata"}, lastw, e.wdata);
                    end
                    wc = 0; nrd = 0; nwr = 0; nerr = 0;
                end
            end
        end
    end

    // Issue one access starting at posedge+1; returns at posedge+1 after completion.
    task automatic do_op(input bit rd, input bit wr, input logic [5:0] op,
                         input logic [31:0] addr, input logic [31:0] wd, input exp_t e);
        bit done = 0;
        q.push_back(e);
        cpu_read = rd; cpu_write = wr; cpu_opcode = op;
        cpu_address = addr; cpu_writedata = wd;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (!cpu_waitrequest) done = 1;
        end
        if (!done) begin
            nvec++; nfail++;
            $display("FAIL %s.timeout: got stalled expected done", e.name);
            void'(q.pop_front());
        end
        @(posedge clk); #1;
        cpu_read = 0; cpu_write = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
        mem[0] = 32'h01234567;
        mem[2] = 32'h11223344;
        mem[5] = 32'h8899AABB;

        // Reset state, with a request held during reset.
        repeat (2) @(posedge clk);
        #1 cpu_read = 1; cpu_opcode = 6'h23;
        @(negedge clk);
        chk("rst.readdata", cpu_readdata, 32'h0);
        chk("rst.mem_err", {31'b0, mem_err}, 32'h0);
        chk("rst.waitreq", {31'b0, cpu_waitrequest}, 32'h0);
        chk("rst.ram_read", {31'b0, ram_read}, 32'h0);
        @(posedge clk); #1 cpu_read = 0; reset = 1;
        @(posedge clk); #1;

        // Loads from RAM[5]=8899AABB
        do_op(1, 0, 6'h20, 32'h15, 0, mk("lb15",  32'hFFFFFF99, 1, 0, 1, 1, 0, 0));
        do_op(1, 0, 6'h24, 32'h15, 0, mk("lbu15", 32'h00000099, 1, 0, 1, 1, 0, 0));
        do_op(1, 0, 6'h21, 32'h16, 0, mk("lh16",  32'hFFFFAABB, 1, 0, 1, 1, 0, 0));
        do_op(1, 0, 6'h25, 32'h14, 0, mk("lhu14", 32'h00008899, 1, 0, 1, 1, 0, 0));
        do_op(1, 0, 6'h23, 32'h14, 0, mk("lw14",  32'h8899AABB, 1, 0, 1, 1, 0, 0));
        do_op(1, 0, 6'h20, 32'h17, 0, mk("lb17",  32'hFFFFFFBB, 1, 0, 1, 1, 0, 0));
        do_op(1, 0, 6'h00, 32'h14, 0, mk("op00",  32'h8899AABB, 1, 0, 1, 1, 0, 0));
        do_op(1, 0, 6'h23, 32'h1014, 0, mk("wrap", 32'h8899AABB, 1, 0, 1, 1, 0, 0));
        // Idle: readdata holds.
        @(negedge clk); chk("idle.hold", cpu_readdata, 32'h8899AABB);
        @(posedge clk); #1;

        // Sub-word stores to RAM[2]=11223344
        do_op(0, 1, 6'h28, 32'h0B, 32'h000000EE, mk("sb0b", 0, 0, 0, 1, 1, 1, 32'h112233EE));
        chk("sb0b.mem", mem[2], 32'h112233EE);
        do_op(0, 1, 6'h29, 32'h08, 32'h0000CAFE, mk("sh08", 0, 0, 0, 1, 1, 1, 32'hCAFE33EE));
        chk("sh08.mem", mem[2], 32'hCAFE33EE);
        do_op(0, 1, 6'h2B, 32'h20, 32'hDEADBEEF, mk("sw20", 0, 0, 0, 0, 0, 1, 32'hDEADBEEF));
        chk("sw20.mem", mem[8], 32'hDEADBEEF);

        // Rejected accesses
        do_op(1, 0, 6'h23, 32'h13, 0, mk("lw13", 32'h0, 1, 1, 1, 0, 0, 0));
        do_op(0, 1, 6'h29, 32'h09, 32'h1234, mk("sh09", 32'h0, 1, 1, 1, 0, 0, 0));
        chk("sh09.mem", mem[2], 32'hCAFE33EE);
        do_op(1, 1, 6'h23, 32'h00, 32'h5555, mk("rdwr", 32'h0, 1, 1, 1, 0, 0, 0));
        chk("rdwr.mem", mem[0], 32'h01234567);

        // Reset in the middle of an SB read-modify-write.
        do_op(1, 0, 6'h23, 32'h14, 0, mk("lw_pre", 32'h8899AABB, 1, 0, 1, 1, 0, 0));
        cpu_write = 1; cpu_opcode = 6'h28; cpu_address = 32'h0B; cpu_writedata = 32'h55;
        @(negedge clk);
        chk("rmwrst.waitreq0", {31'b0, cpu_waitrequest}, 32'h1);
        @(posedge clk); #1 reset = 0; cpu_write = 0;
        @(negedge clk);
        chk("rmwrst.ram_write", {31'b0, ram_write}, 32'h0);
        chk("rmwrst.waitreq", {31'b0, cpu_waitrequest}, 32'h0);
        chk("rmwrst.readdata", cpu_readdata, 32'h0);
        @(posedge clk); #1 reset = 1;
        @(negedge clk);
        chk("rmwrst.mem", mem[2], 32'hCAFE33EE);
        @(posedge clk); #1;
        do_op(1, 0, 6'h23, 32'h00, 0, mk("lw00", 32'h01234567, 1, 0, 1, 1, 0, 0));

        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
